// File: rtl/nfc_phy_pkg.sv
// nfc_phy_pkg
//   Shared definitions for the NAND R/B tracker:
//   - way_state_e : per-way FSM state (IDLE / ARMED / BUSY)
//   - Def*        : default parameter values used by the tracker modules
package nfc_phy_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BUSY  = 2'd2
  } way_state_e;

  localparam int unsigned DefNumberOfWays = 4;
  localparam int unsigned DefSyncStages   = 2;
  localparam int unsigned DefFilterCycles = 4;
  localparam int unsigned DefArmWindow    = 16;
  localparam int unsigned DefTimeoutWidth = 24;

endpackage

// File: rtl/nfc_phy_rb_way.sv
// nfc_phy_rb_way
//   One R/B way: synchronizer, glitch filter, IDLE/ARMED/BUSY tracker and
//   (with NFC_RB_TIMEOUT_EN defined) an operation timeout counter.
//   Ports:
//     clk_i, rst_i      : clock, synchronous active-high reset
//     rb_pin_i          : asynchronous R/B pin (1 = ready)
//     arm_i             : pulse, a busy-causing command was issued
//     tmo_limit_i       : timeout in cycles, 0 = disabled
//     ready_busy_o      : filtered R/B level
//     ready_evt_o       : one-cycle pulse, operation complete
//     timeout_o         : one-cycle pulse, operation timed out
//     way_busy_o        : 1 while ARMED or BUSY
//     state_o           : FSM state, for debug
//   Handshake: arm_i is a single-cycle strobe with no back-pressure; it is
//   accepted only in IDLE and silently dropped otherwise.
module nfc_phy_rb_way
  import nfc_phy_pkg::*;
#(
  parameter int unsigned SyncStages   = DefSyncStages,
  parameter int unsigned FilterCycles = DefFilterCycles,
  parameter int unsigned ArmWindow    = DefArmWindow,
  parameter int unsigned TimeoutWidth = DefTimeoutWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rb_pin_i,
  input  logic                    arm_i,
  input  logic [TimeoutWidth-1:0] tmo_limit_i,
  output logic                    ready_busy_o,
  output logic                    ready_evt_o,
  output logic                    timeout_o,
  output logic                    way_busy_o,
  output way_state_e              state_o
);

  localparam logic [3:0] FiltMax = 4'(FilterCycles - 1);
  localparam logic [7:0] WinMax  = 8'(ArmWindow - 1);

  logic [SyncStages-1:0] sync_q;
  logic                  sync_out;
  logic                  rb_q, rb_d;
  logic [3:0]            filt_q, filt_d;
  logic [7:0]            win_q;
  way_state_e            state_q;
  logic                  ready_evt_q, tmo_evt_q, busy_q;
  logic                  tmo_hit;

  assign sync_out = sync_q[SyncStages-1];

  // Filter: the level flips on the edge where the disagreement has lasted
  // FilterCycles consecutive cycles; any agreeing cycle restarts the count.
  always_comb begin
    rb_d   = rb_q;
    filt_d = '0;
    if (sync_out != rb_q) begin
      if (filt_q == FiltMax) rb_d = sync_out;
      else                   filt_d = filt_q + 4'd1;
    end
  end

`ifdef NFC_RB_TIMEOUT_EN
  logic [TimeoutWidth-1:0] tmo_q, tmo_inc;

  // Saturating increment; hit is judged on the value being counted to, so
  // the pulse lands limit cycles after ARMED entry.
  assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + 1'b1;
  assign tmo_hit = (state_q != IDLE) && (tmo_limit_i != '0) && (tmo_inc == tmo_limit_i);

  // Held at zero in IDLE, which clears it on entry to ARMED.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == IDLE) tmo_q <= '0;
    else                          tmo_q <= tmo_inc;
  end
`else
  logic unused_tmo_limit;
  assign unused_tmo_limit = ^tmo_limit_i;
  assign tmo_hit          = 1'b0;
`endif

  // FSM decisions use rb_d so completion is flagged on the same edge the
  // filtered level changes; rb_d comes only from registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q      <= '1;
      rb_q        <= 1'b1;
      filt_q      <= '0;
      win_q       <= '0;
      state_q     <= IDLE;
      ready_evt_q <= 1'b0;
      tmo_evt_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SyncStages-2:0], rb_pin_i};
      rb_q        <= rb_d;
      filt_q      <= filt_d;
      ready_evt_q <= 1'b0;
      tmo_evt_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arm_i) begin
            state_q <= ARMED;
            win_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ARMED: begin
          if (tmo_hit) begin
            state_q   <= IDLE;
            tmo_evt_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (!rb_d) begin
            state_q <= BUSY;
          end else if (win_q == WinMax) begin
            // Busy never seen: the operation finished faster than we could observe.
            state_q     <= IDLE;
            ready_evt_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            win_q <= win_q + 8'd1;
          end
        end
        BUSY: begin
          if (tmo_hit) begin
            state_q   <= IDLE;
            tmo_evt_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (rb_d) begin
            state_q     <= IDLE;
            ready_evt_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_busy_o = rb_q;
  assign ready_evt_o  = ready_evt_q;
  assign timeout_o    = tmo_evt_q;
  assign way_busy_o   = busy_q;
  assign state_o      = state_q;

endmodule

// File: rtl/nfc_phy_rb_tracker.sv
// nfc_phy_rb_tracker
//   Tracks NumberOfWays NAND R/B pins, one independent nfc_phy_rb_way each.
//   Optional feature macro: NFC_RB_TIMEOUT_EN (per-way operation timeout).
//   Ports:
//     iSystemClock, iModuleReset : clock, synchronous active-high reset
//     I_NAND_RB     : asynchronous R/B pins (1 = ready)
//     iArm          : per-way arm pulse after a busy-causing command
//     iTimeoutLimit : timeout in cycles, 0 = disabled
//     oReadyBusy    : filtered R/B levels
//     oReadyEvent   : per-way completion pulse
//     oTimeout      : per-way timeout pulse
//     oWayBusy      : per-way ARMED/BUSY indication
//     oWayState     : per-way FSM state, for debug
module nfc_phy_rb_tracker
  import nfc_phy_pkg::*;
#(
  parameter int unsigned NumberOfWays = DefNumberOfWays,
  parameter int unsigned SyncStages   = DefSyncStages,
  parameter int unsigned FilterCycles = DefFilterCycles,
  parameter int unsigned ArmWindow    = DefArmWindow,
  parameter int unsigned TimeoutWidth = DefTimeoutWidth
) (
  input  logic                    iSystemClock,
  input  logic                    iModuleReset,
  input  logic [NumberOfWays-1:0] I_NAND_RB,
  input  logic [NumberOfWays-1:0] iArm,
  input  logic [TimeoutWidth-1:0] iTimeoutLimit,
  output logic [NumberOfWays-1:0] oReadyBusy,
  output logic [NumberOfWays-1:0] oReadyEvent,
  output logic [NumberOfWays-1:0] oTimeout,
  output logic [NumberOfWays-1:0] oWayBusy,
  output way_state_e              oWayState [NumberOfWays]
);

  for (genvar w = 0; w < NumberOfWays; w++) begin : g_way
    nfc_phy_rb_way #(
      .SyncStages   (SyncStages),
      .FilterCycles (FilterCycles),
      .ArmWindow    (ArmWindow),
      .TimeoutWidth (TimeoutWidth)
    ) u_way (
      .clk_i        (iSystemClock),
      .rst_i        (iModuleReset),
      .rb_pin_i     (I_NAND_RB[w]),
      .arm_i        (iArm[w]),
      .tmo_limit_i  (iTimeoutLimit),
      .ready_busy_o (oReadyBusy[w]),
      .ready_evt_o  (oReadyEvent[w]),
      .timeout_o    (oTimeout[w]),
      .way_busy_o   (oWayBusy[w]),
      .state_o      (oWayState[w])
    );
  end

endmodule

// File: tb/tb_nfc_phy_rb_tracker.sv
// tb_nfc_phy_rb_tracker
//   Directed bench for nfc_phy_rb_tracker with default parameters
//   (SyncStages=2, FilterCycles=4, ArmWindow=16). Expected pulses carry the
//   cycle count at which they must be visible on the falling edge.
//   Honours NFC_RB_TIMEOUT_EN for the timeout expectations.
module tb_nfc_phy_rb_tracker;
  import nfc_phy_pkg::*;

  localparam int NW = 4;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [NW-1:0] rb, arm;
  logic [TW-1:0] lim;
  logic [NW-1:0] o_rb, o_evt, o_tmo, o_busy;
  way_state_e    o_state [NW];

  nfc_phy_rb_tracker dut (
    .iSystemClock  (clk),
    .iModuleReset  (rst),
    .I_NAND_RB     (rb),
    .iArm          (arm),
    .iTimeoutLimit (lim),
    .oReadyBusy    (o_rb),
    .oReadyEvent   (o_evt),
    .oTimeout      (o_tmo),
    .oWayBusy      (o_busy),
    .oWayState     (o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int            at;
    logic [NW-1:0] ev;
    logic [NW-1:0] to;
  } exp_t;
  exp_t exp_q[$];

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int at, input logic [NW-1:0] ev, input logic [NW-1:0] to);
    exp_t e;
    e.at = at;
    e.ev = ev;
    e.to = to;
    exp_q.push_back(e);
  endtask

  // Monitor: every pulse cycle must match the next queued expectation.
  always @(negedge clk) begin
    if ((o_evt !== '0) || (o_tmo !== '0)) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_pulse: evt=%0h tmo=%0h expected none (cycle %0d)", o_evt, o_tmo, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc, e.at);
        check("pulse_evt", {28'd0, o_evt}, {28'd0, e.ev});
        check("pulse_tmo", {28'd0, o_tmo}, {28'd0, e.to});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c;
  logic [NW-1:0] exp_busy3;

  initial begin
    rst = 1'b1;
    rb  = '1;
    arm = '0;
    lim = '0;
    tick(3);
    check("reset_rb",   {28'd0, o_rb},   32'hF);
    check("reset_busy", {28'd0, o_busy}, 32'h0);
    check("reset_evt",  {28'd0, o_evt | o_tmo}, 32'h0);
    rst = 1'b0;
    tick(10);
    check("idle_rb",   {28'd0, o_rb},   32'hF);
    check("idle_busy", {28'd0, o_busy}, 32'h0);

    // Glitch of 3 cycles on way 0: filtered level must not move.
    rb[0] = 1'b0;
    tick(3);
    rb[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("glitch_rb0", {31'd0, o_rb[0]}, 32'd1);
    end

    // Sustained low on way 0 (not armed): latency exactly 6 cycles.
    c = cyc;
    rb[0] = 1'b0;
    tick(5);
    check("lat_rb0_before", {31'd0, o_rb[0]}, 32'd1);
    tick(1);
    check("lat_rb0_at", {31'd0, o_rb[0]}, 32'd0);
    check("lat_rb0_cycle", cyc, c + 6);
    rb[0] = 1'b1;
    tick(12);
    check("lat_rb0_back", {31'd0, o_rb[0]}, 32'd1);

    // Normal operation on way 1.
    arm[1] = 1'b1;
    tick(1);
    arm = '0;
    check("arm1_busy", {28'd0, o_busy}, 32'h2);
    tick(1);
    rb[1] = 1'b0;
    tick(100);
    check("op1_rb_low", {28'd0, o_rb}, 32'hD);
    check("op1_busy",   {28'd0, o_busy}, 32'h2);
    c = cyc;
    rb[1] = 1'b1;
    expect_pulse(c + 6, 4'b0010, 4'b0000);
    tick(5);
    check("op1_busy_pre", {28'd0, o_busy}, 32'h2);
    tick(1);
    check("op1_busy_done", {28'd0, o_busy}, 32'h0);
    tick(5);

    // Missed busy on ways 0 and 2 together: window expiry after 16 cycles.
    c = cyc;
    arm = 4'b0101;
    expect_pulse(c + 17, 4'b0101, 4'b0000);
    tick(1);
    arm = '0;
    check("win_busy", {28'd0, o_busy}, 32'h5);
    tick(20);
    check("win_idle", {28'd0, o_busy}, 32'h0);

    // Timeout on way 3 with pin held low.
    lim = 24'd50;
    c = cyc;
    arm[3] = 1'b1;
    rb[3]  = 1'b0;
`ifdef NFC_RB_TIMEOUT_EN
    expect_pulse(c + 51, 4'b0000, 4'b1000);
    exp_busy3 = 4'b0000;
`else
    exp_busy3 = 4'b1000;
`endif
    tick(1);
    arm = '0;
    tick(60);
    check("tmo_busy3", {28'd0, o_busy}, {28'd0, exp_busy3});
    lim = '0;

    // Reset while all ways are busy: abort with no pulses.
    rb  = '0;
    arm = '1;
    tick(1);
    arm = '0;
    tick(12);
    check("all_busy", {28'd0, o_busy}, 32'hF);
    rst = 1'b1;
    tick(1);
    check("abort_busy", {28'd0, o_busy}, 32'h0);
    check("abort_rb",   {28'd0, o_rb},   32'hF);
    check("abort_evt",  {28'd0, o_evt | o_tmo}, 32'h0);
    rb = '1;
    tick(2);
    rst = 1'b0;
    tick(20);
    check("post_busy", {28'd0, o_busy}, 32'h0);
    check("post_rb",   {28'd0, o_rb},   32'hF);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
